// File: rtl/debounce_bank_if.sv
// ---------------------------------------------------------------------------
// debounce_bank_if
// Bundles the per-channel signals of the debouncer bank. The clock and reset
// are not part of this bundle and stay as plain ports on debounce_bank.
//
// Parameters:
//   CHANNELS  number of independent input channels
//
// Signals (all CHANNELS bits wide):
//   d     raw asynchronous inputs (board pins)
//   q     debounced level
//   rise  one-cycle strobe, q[i] went 0->1
//   fall  one-cycle strobe, q[i] went 1->0
//   rpt   one-cycle auto-repeat strobe while a channel is held
//
// Modports:
//   master  the side that drives the pins and consumes the debounced results
//   slave   the debouncer itself
// ---------------------------------------------------------------------------
interface debounce_bank_if #(
    parameter int CHANNELS = 4
) ();

    logic [CHANNELS-1:0] d;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] rpt;

    modport master (
        output d,
        input  q,
        input  rise,
        input  fall,
        input  rpt
    );

    modport slave (
        input  d,
        output q,
        output rise,
        output fall,
        output rpt
    );

endinterface

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
// Multi-channel counter-based debouncer for the keypad/button inputs of the
// digital lock. Each channel passes its raw pin through a 2-flop synchroniser
// and only accepts a new level after STABLE_CYCLES consecutive synchronised
// samples that differ from the current debounced level. Registered one-cycle
// rise/fall strobes accompany every accepted change. Channels are fully
// independent of each other.
//
// Optional feature (compile-time macro DEBOUNCE_REPEAT_EN):
//   When defined, a per-channel repeat counter produces an rpt pulse
//   REPEAT_DELAY cycles after a rise strobe, and then every REPEAT_PERIOD
//   cycles while the channel stays pressed. When undefined, no repeat logic
//   exists and rpt is constant 0.
//
// Parameters:
//   CHANNELS       number of channels (>=1)
//   STABLE_CYCLES  consecutive differing samples needed to accept a change (>=1)
//   IDLE_LEVEL     reset value of every synchroniser flop and q bit
//   REPEAT_DELAY   cycles from rise to first rpt (repeat build only)
//   REPEAT_PERIOD  cycles between later rpt pulses (repeat build only)
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    debounce_bank_if.slave: d in; q, rise, fall, rpt out
// ---------------------------------------------------------------------------
module debounce_bank #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 100000,
    parameter logic IDLE_LEVEL    = 1'b0,
    parameter int   REPEAT_DELAY  = 50000000,
    parameter int   REPEAT_PERIOD = 10000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    debounce_bank_if.slave        bus
);

    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic [CHANNELS-1:0] s1_r;
    logic [CHANNELS-1:0] s2_r;
    logic [CHANNELS-1:0] q_r;
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;
    logic [CW-1:0]       cnt_r     [CHANNELS];
    logic [CW-1:0]       cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0] accept_s;

    // Stability counters: count samples that disagree with q, restart on any agreeing sample.
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt_s[i] = '0;
            if (s2_r[i] != q_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    // Last required sample: take the new level, counter restarts.
                    accept_s[i]  = 1'b1;
                    cnt_nxt_s[i] = '0;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = '0;
            end
        end
    end

    // Synchroniser, debounced level, strobes and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r   <= {CHANNELS{IDLE_LEVEL}};
            s2_r   <= {CHANNELS{IDLE_LEVEL}};
            q_r    <= {CHANNELS{IDLE_LEVEL}};
            rise_r <= '0;
            fall_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            s1_r   <= bus.d;
            s2_r   <= s1_r;
            // An accepted channel always has s2 != q, so toggling q loads s2.
            q_r    <= q_r ^ accept_s;
            rise_r <= accept_s & s2_r;
            fall_r <= accept_s & ~s2_r;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int            RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD;
    localparam int            RW          = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_ONE    = RW'(1'b1);

    logic [RW-1:0]       rcnt_r       [CHANNELS];
    logic [RW-1:0]       rcnt_nxt_s   [CHANNELS];
    logic [CHANNELS-1:0] rphase_r;
    logic [CHANNELS-1:0] rphase_nxt_s;
    logic [CHANNELS-1:0] rpt_r;
    logic [CHANNELS-1:0] rpt_nxt_s;

    // Repeat timing: rphase selects initial delay (0) or steady period (1).
    always_comb begin
        rpt_nxt_s    = '0;
        rphase_nxt_s = rphase_r;
        for (int i = 0; i < CHANNELS; i++) begin
            rcnt_nxt_s[i] = rcnt_r[i];
            // Clearing on any accepted change keeps rpt off the rise and fall cycles.
            if (accept_s[i] || !q_r[i]) begin
                rcnt_nxt_s[i]   = '0;
                rphase_nxt_s[i] = 1'b0;
            end else if (rcnt_r[i] == (rphase_r[i] ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_nxt_s[i]    = 1'b1;
                rcnt_nxt_s[i]   = '0;
                rphase_nxt_s[i] = 1'b1;
            end else begin
                rcnt_nxt_s[i] = rcnt_r[i] + RCNT_ONE;
            end
        end
    end

    // Repeat counter, phase and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rphase_r <= '0;
            rpt_r    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt_r[i] <= '0;
            end
        end else begin
            rphase_r <= rphase_nxt_s;
            rpt_r    <= rpt_nxt_s;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt_r[i] <= rcnt_nxt_s[i];
            end
        end
    end

    assign bus.rpt = rpt_r;
`else
    // Repeat timing parameters have no meaning without the repeat logic.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

    assign bus.rpt = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Bounce pattern applied to d[1], one value per clock.
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    debounce_bank_if #(.CHANNELS(4)) bus ();

    debounce_bank #(
        .CHANNELS      (4),
        .STABLE_CYCLES (4),
        .IDLE_LEVEL    (1'b0),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eq,
                              input logic [3:0] er, input logic [3:0] ef);
        chk({tag, "/q"},    bus.q,    eq);
        chk({tag, "/rise"}, bus.rise, er);
        chk({tag, "/fall"}, bus.fall, ef);
`ifndef DEBOUNCE_REPEAT_EN
        chk({tag, "/rpt"},  bus.rpt,  4'h0);
`endif
    endtask

    initial begin
        logic [3:0] eq;
        logic [3:0] er;
        logic [3:0] ef;
        logic [3:0] erp;

        // 1. Reset with all inputs high, then release.
        rst_n  = 1'b0;
        bus.d  = 4'hF;
        #2;
        for (int s = 1; s <= 3; s++) begin
            step();
            expect_out($sformatf("t1_rst_s%0d", s), 4'h0, 4'h0, 4'h0);
            chk($sformatf("t1_rst_s%0d/rpt", s), bus.rpt, 4'h0);
        end
        rst_n = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            step();
            eq = (s >= 6) ? 4'hF : 4'h0;
            er = (s == 6) ? 4'hF : 4'h0;
            expect_out($sformatf("t1_rel_s%0d", s), eq, er, 4'h0);
            chk($sformatf("t1_rel_s%0d/rpt", s), bus.rpt, 4'h0);
        end

        // Back to idle on all channels.
        bus.d = 4'h0;
        for (int s = 1; s <= 7; s++) begin
            step();
            eq = (s >= 6) ? 4'h0 : 4'hF;
            ef = (s == 6) ? 4'hF : 4'h0;
            expect_out($sformatf("t1_idle_s%0d", s), eq, 4'h0, ef);
        end

        // 2. Clean press on channel 0.
        bus.d = 4'b0001;
        for (int s = 1; s <= 7; s++) begin
            step();
            eq = (s >= 6) ? 4'b0001 : 4'b0000;
            er = (s == 6) ? 4'b0001 : 4'b0000;
            expect_out($sformatf("t2_s%0d", s), eq, er, 4'h0);
        end

        // 3. Bouncing press on channel 1.
        for (int p = 0; p < 9; p++) begin
            bus.d[1] = pat[p];
            step();
            expect_out($sformatf("t3_p%0d", p + 1), 4'b0001, 4'h0, 4'h0);
        end
        step();
        expect_out("t3_s10", 4'b0001, 4'h0, 4'h0);
        step();
        expect_out("t3_s11", 4'b0011, 4'b0010, 4'h0);
        step();
        expect_out("t3_s12", 4'b0011, 4'h0, 4'h0);

        // 4a. Three-cycle glitch on channel 2 is rejected.
        bus.d[2] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            if (s == 4) bus.d[2] = 1'b0;
            step();
            expect_out($sformatf("t4a_s%0d", s), 4'b0011, 4'h0, 4'h0);
        end

        // 4b. Four-cycle pulse on channel 2 is accepted, then released.
        bus.d[2] = 1'b1;
        for (int s = 1; s <= 11; s++) begin
            if (s == 5) bus.d[2] = 1'b0;
            step();
            eq = (s >= 6 && s < 10) ? 4'b0111 : 4'b0011;
            er = (s == 6)  ? 4'b0100 : 4'b0000;
            ef = (s == 10) ? 4'b0100 : 4'b0000;
            expect_out($sformatf("t4b_s%0d", s), eq, er, ef);
        end

        // 5. Mid-count reset on channel 0.
        bus.d = 4'h0;
        for (int s = 1; s <= 7; s++) begin
            step();
            eq = (s >= 6) ? 4'b0000 : 4'b0011;
            ef = (s == 6) ? 4'b0011 : 4'b0000;
            expect_out($sformatf("t5_idle_s%0d", s), eq, 4'h0, ef);
        end
        bus.d = 4'b0001;
        for (int s = 1; s <= 3; s++) begin
            step();
            expect_out($sformatf("t5_pre_s%0d", s), 4'h0, 4'h0, 4'h0);
        end
        rst_n = 1'b0;
        #1;
        expect_out("t5_rst_async", 4'h0, 4'h0, 4'h0);
        for (int s = 1; s <= 2; s++) begin
            step();
            expect_out($sformatf("t5_rst_s%0d", s), 4'h0, 4'h0, 4'h0);
        end
        rst_n = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            step();
            eq = (s >= 6) ? 4'b0001 : 4'b0000;
            er = (s == 6) ? 4'b0001 : 4'b0000;
            expect_out($sformatf("t5_rel_s%0d", s), eq, er, 4'h0);
        end

        // 6. Long hold on channel 3: auto-repeat when built in, none otherwise.
        bus.d = 4'h0;
        for (int s = 1; s <= 7; s++) begin
            step();
            eq = (s >= 6) ? 4'b0000 : 4'b0001;
            ef = (s == 6) ? 4'b0001 : 4'b0000;
            expect_out($sformatf("t6_idle_s%0d", s), eq, 4'h0, ef);
        end
        bus.d = 4'b1000;
        for (int s = 1; s <= 35; s++) begin
            if (s == 24) bus.d = 4'h0;
            step();
            eq = (s >= 6 && s < 29) ? 4'b1000 : 4'b0000;
            er = (s == 6)  ? 4'b1000 : 4'b0000;
            ef = (s == 29) ? 4'b1000 : 4'b0000;
`ifdef DEBOUNCE_REPEAT_EN
            erp = (s >= 16 && s <= 28 && ((s - 16) % 3) == 0) ? 4'b1000 : 4'b0000;
`else
            erp = 4'b0000;
`endif
            expect_out($sformatf("t6_s%0d", s), eq, er, ef);
            chk($sformatf("t6_s%0d/rpt", s), bus.rpt, erp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
